// File: rtl/ipsxe_floating_point_op_sequencer.sv
// Operation-table sequencer: streams table entries 0..last_addr
// over a valid/ready port, optionally looping until stopped.
module ipsxe_floating_point_op_sequencer #(
    parameter int                ADDR_W        = 4,
    parameter int                DATA_W        = 8,
    parameter logic [DATA_W-1:0] DEFAULT_ENTRY = DATA_W'(8'h08)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_err,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic              loop_en,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W-1:0] m_addr,
    output logic              busy,
    output logic              done
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_table [DEPTH];
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_last;
    logic [ADDR_W-1:0] r_maddr;
    logic [DATA_W-1:0] r_mdata;
    logic              r_loop;
    logic              r_stop_pend;
    logic              r_wr_err;
    logic              w_hs;
    logic              w_at_last;
    logic              w_wr_ok;

    assign w_hs      = (r_state == S_ISSUE) && m_ready;
    assign w_at_last = (r_idx == r_last);
    assign w_wr_ok   = wr_en && (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_next = S_FETCH;
            S_FETCH: w_next = S_ISSUE;
            S_ISSUE: begin
                if (w_hs) begin
                    if (!w_at_last)
                        w_next = S_FETCH;
                    else if (r_loop && !r_stop_pend)
                        w_next = S_FETCH;
                    else
                        w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Table is writable only while idle so an issued sequence is coherent.
    always_ff @(posedge clk) begin
        if (rst)
            r_table <= '{default: DEFAULT_ENTRY};
        else if (w_wr_ok)
            r_table[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx       <= '0;
            r_last      <= '0;
            r_loop      <= 1'b0;
            r_maddr     <= '0;
            r_mdata     <= DEFAULT_ENTRY;
            r_stop_pend <= 1'b0;
            r_wr_err    <= 1'b0;
        end else begin
            r_wr_err <= wr_en && (r_state != S_IDLE);
            if (r_state == S_IDLE)
                r_stop_pend <= 1'b0;
            else if (stop)
                r_stop_pend <= 1'b1;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_last <= last_addr;
                        r_loop <= loop_en;
                        r_idx  <= '0;
                    end
                end
                S_FETCH: begin
                    r_mdata <= r_table[r_idx];
                    r_maddr <= r_idx;
                end
                S_ISSUE: begin
                    if (m_ready)
                        r_idx <= w_at_last ? '0 : r_idx + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign m_valid = (r_state == S_ISSUE);
    assign m_data  = r_mdata;
    assign m_addr  = r_maddr;
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_DONE);
    assign wr_err  = r_wr_err;

endmodule
